// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus memory-mapped LED, switch, timer and TX FIFO.
// Loads are combinational from Addr; stores and all register updates land on the rising edge.
module dmem_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = PW + 1;

  // Word addresses (Addr[11:2]) of the I/O registers
  localparam logic [9:0] A_LED    = 10'h100;
  localparam logic [9:0] A_SW     = 10'h101;
  localparam logic [9:0] A_TIMER  = 10'h102;
  localparam logic [9:0] A_TXDATA = 10'h103;
  localparam logic [9:0] A_TXSTAT = 10'h104;
  localparam logic [9:0] A_TXCLR  = 10'h105;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [7:0]        fifo_q [FIFO_DEPTH];

  logic [7:0]        led_q;
  logic [7:0]        sw_meta_q;
  logic [7:0]        sw_sync_q;
  logic [31:0]       timer_q, timer_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [9:0]        waddr;
  logic              hi_zero;
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_led, sel_sw, sel_timer, sel_txdata, sel_txstat, sel_txclr;
  logic              we;
  logic              full, empty, push, pop;
  logic [31:0]       txstat;
  logic [1:0]        unused_byte_lanes;

  assign unused_byte_lanes = Addr[1:0];

  // Address decode
  assign waddr      = Addr[11:2];
  assign hi_zero    = (Addr[31:12] == 20'd0);
  assign ram_hit    = hi_zero && (Addr[11:10] == 2'b00) &&
                      ({24'd0, Addr[9:2]} < 32'(RAM_WORDS));
  assign ram_idx    = Addr[2 +: RAM_AW];
  assign sel_led    = hi_zero && (waddr == A_LED);
  assign sel_sw     = hi_zero && (waddr == A_SW);
  assign sel_timer  = hi_zero && (waddr == A_TIMER);
  assign sel_txdata = hi_zero && (waddr == A_TXDATA);
  assign sel_txstat = hi_zero && (waddr == A_TXSTAT);
  assign sel_txclr  = hi_zero && (waddr == A_TXCLR);

  // A store coinciding with reset is dropped everywhere, RAM included
  assign we = MemWrite && !reset;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = we && sel_txdata && !full;
  assign pop      = !empty && tx_ready;
  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign led      = led_q;

  assign txstat = {23'd0, 5'(count_q), 1'b0, ovf_q, empty, full};

  always_comb begin
    ReadData = 32'd0;
    if (ram_hit)         ReadData = ram_q[ram_idx];
    else if (sel_led)    ReadData = {24'd0, led_q};
    else if (sel_sw)     ReadData = {24'd0, sw_sync_q};
    else if (sel_timer)  ReadData = timer_q;
    else if (sel_txstat) ReadData = txstat;
  end

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (we && sel_timer) timer_d = WriteData;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // A dropped push in the same cycle as a clear still leaves overflow set
  always_comb begin
    ovf_d = ovf_q;
    if (we && sel_txclr) ovf_d = 1'b0;
    if (we && sel_txdata && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= 8'd0;
      sw_meta_q <= 8'd0;
      sw_sync_q <= 8'd0;
      timer_q   <= 32'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (we && sel_led) led_q <= WriteData[7:0];
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      timer_q   <= timer_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays carry no reset; contents are meaningful only once written
  always_ff @(posedge clk) begin
    if (we && ram_hit) ram_q[ram_idx] <= WriteData;
    if (push) fifo_q[wr_ptr_q] <= WriteData[7:0];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, LED, switch sync, timer, TX FIFO and reset behaviour.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .sw(sw), .led(led),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
    WriteData = 32'd0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    sw    = 8'hFF;
    repeat (3) tick();
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp %h", led, 8'h00); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txvalid got %b exp 0", tx_valid); end
    load(32'h410, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL reset_txstat got %h exp %h", v, 32'h2); end
    load(32'h404, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_sw got %h exp %h", v, 32'h0); end
    sw    = 8'h00;
    reset = 1'b0;
    load(32'h408, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_timer got %h exp %h", v, 32'h0); end
    tick();
    load(32'h408, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL timer_first_inc got %h exp %h", v, 32'h1); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    store(32'h000, 32'h11111111);
    store(32'h010, 32'hDEADBEEF);
    load(32'h010, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_load got %h exp %h", v, 32'hDEADBEEF); end
    load(32'h013, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_byteoff got %h exp %h", v, 32'hDEADBEEF); end
    load(32'h800, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp %h", v, 32'h0); end
    // Same-cycle read during a store sees the old word
    MemWrite = 1'b1; Addr = 32'h010; WriteData = 32'hCAFEF00D;
    #1;
    checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_same_cycle got %h exp %h", ReadData, 32'hDEADBEEF); end
    tick();
    MemWrite = 1'b0;
    load(32'h010, v);
    checks++; if (v !== 32'hCAFEF00D) begin errors++; $display("FAIL ram_overwrite got %h exp %h", v, 32'hCAFEF00D); end
    store(32'h010, 32'hDEADBEEF);
    store(32'h800, 32'h12345678);
    store(32'h1000_0010, 32'h87654321);
    load(32'h000, v);
    checks++; if (v !== 32'h11111111) begin errors++; $display("FAIL unmapped_write_alias0 got %h exp %h", v, 32'h11111111); end
    load(32'h010, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL highaddr_write_alias got %h exp %h", v, 32'hDEADBEEF); end
    load(32'h1000_0010, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL highaddr_read got %h exp %h", v, 32'h0); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL unmapped_write_led got %h exp %h", led, 8'h00); end
  endtask

  task automatic test_led_sw();
    logic [31:0] v;
    store(32'h400, 32'h1A5);
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL led_out got %h exp %h", led, 8'hA5); end
    load(32'h400, v);
    checks++; if (v !== 32'hA5) begin errors++; $display("FAIL led_read got %h exp %h", v, 32'hA5); end
    store(32'h404, 32'hFF);
    sw = 8'h3C;
    load(32'h404, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_edge0 got %h exp %h", v, 32'h0); end
    tick();
    load(32'h404, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_edge1 got %h exp %h", v, 32'h0); end
    tick();
    load(32'h404, v);
    checks++; if (v !== 32'h3C) begin errors++; $display("FAIL sw_edge2 got %h exp %h", v, 32'h3C); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    store(32'h408, 32'hFFFFFFFE);
    load(32'h408, v);
    checks++; if (v !== 32'hFFFFFFFE) begin errors++; $display("FAIL timer_load got %h exp %h", v, 32'hFFFFFFFE); end
    tick();
    load(32'h408, v);
    checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL timer_inc got %h exp %h", v, 32'hFFFFFFFF); end
    tick();
    load(32'h408, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL timer_wrap got %h exp %h", v, 32'h0); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] v;
    tx_ready = 1'b0;
    store(32'h40C, 32'h41);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL fifo_first_push got v=%b d=%h exp v=1 d=41", tx_valid, tx_data); end
    for (int i = 1; i < 8; i++) store(32'h40C, 32'(8'h41 + i));
    load(32'h410, v);
    checks++; if (v !== 32'h81) begin errors++; $display("FAIL fifo_full_stat got %h exp %h", v, 32'h81); end
    store(32'h40C, 32'h49);
    load(32'h410, v);
    checks++; if (v !== 32'h85) begin errors++; $display("FAIL fifo_overflow_stat got %h exp %h", v, 32'h85); end
    load(32'h40C, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL txdata_read got %h exp %h", v, 32'h0); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        errors++; $display("FAIL fifo_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained_valid got %b exp 0", tx_valid); end
    load(32'h410, v);
    checks++; if (v !== 32'h06) begin errors++; $display("FAIL fifo_empty_stat got %h exp %h", v, 32'h06); end
    store(32'h414, 32'h0);
    load(32'h410, v);
    checks++; if (v !== 32'h02) begin errors++; $display("FAIL fifo_clr_stat got %h exp %h", v, 32'h02); end
    load(32'h414, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL txclr_read got %h exp %h", v, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h40C, 32'(8'h50 + i));
    load(32'h410, v);
    checks++; if (v !== 32'h30) begin errors++; $display("FAIL b2b_initial_stat got %h exp %h", v, 32'h30); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MemWrite = 1'b1; Addr = 32'h40C; WriteData = 32'(8'h53 + i);
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h50 + i)) begin
        errors++; $display("FAIL b2b_head[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(8'h50 + i));
      end
      tick();
    end
    MemWrite = 1'b0;
    tx_ready = 1'b0;
    load(32'h410, v);
    checks++; if (v !== 32'h30) begin errors++; $display("FAIL b2b_count_stat got %h exp %h", v, 32'h30); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h54 + i)) begin
        errors++; $display("FAIL b2b_tail[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(8'h54 + i));
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_midreset();
    logic [31:0] v;
    store(32'h400, 32'h77);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h40C, 32'(8'h60 + i));
    reset = 1'b1;
    MemWrite = 1'b1; Addr = 32'h40C; WriteData = 32'h99;
    tick();
    reset = 1'b0;
    MemWrite = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", tx_valid); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL midreset_led got %h exp %h", led, 8'h00); end
    load(32'h410, v);
    checks++; if (v !== 32'h02) begin errors++; $display("FAIL midreset_stat got %h exp %h", v, 32'h02); end
    load(32'h408, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL midreset_timer got %h exp %h", v, 32'h0); end
    reset = 1'b1;
    MemWrite = 1'b1; Addr = 32'h010; WriteData = 32'hBAD0BAD0;
    tick();
    reset = 1'b0;
    MemWrite = 1'b0;
    load(32'h010, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_store_ignored got %h exp %h", v, 32'hDEADBEEF); end
  endtask

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    Addr      = 32'd0;
    WriteData = 32'd0;
    sw        = 8'd0;
    tx_ready  = 1'b0;
    test_reset();
    test_ram();
    test_led_sw();
    test_timer();
    test_fifo_overflow();
    test_back_to_back();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the single-cycle ARM core; it sits on the core's data bus (MemWrite / address / WriteData / ReadData) and answers every load and store. It contains a word-addressed data RAM and a small memory-mapped I/O region: an LED register, a synchronized switch input, a free-running timer, and a byte transmit FIFO drained over a valid/ready stream. Reads are combinational because the core completes a load in one cycle. Writes take effect on the rising clock edge.

## Interface
- RAM_WORDS, 256: data RAM depth in 32-bit words; power of two, at most 256.
- FIFO_DEPTH, 8: TX FIFO depth in bytes; power of two, 2..16.
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- MemWrite  in  1  store strobe from core
- Addr  in  32  byte address (core ALUResult)
- WriteData  in  32  store data
- ReadData  out  32  load data, combinational from Addr
- sw  in  8  asynchronous board switches
- led  out  8  LED register
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  downstream accepts head byte

## Operation
- Only Addr[11:2] is decoded; Addr[1:0] is ignored (word access only); Addr[31:12] must be zero, otherwise the access is unmapped.
- Address map:
  - 0x000–0x3FF: RAM. The index is Addr[9:2]. An index ≥ RAM_WORDS is unmapped.
  - 0x400: LED. RW. Writes store WriteData[7:0]. Reads return {24'b0, led}.
  - 0x404: SW. RO. Reads return {24'b0, sw_sync}. sw_sync is the output of a 2-flop synchronizer.
  - 0x408: TIMER. RW. 32-bit up-counter, +1 every cycle, wraps 0xFFFFFFFF→0. A write loads WriteData; that cycle the counter loads and does not increment.
  - 0x40C: TXDATA. WO. A write pushes WriteData[7:0]. A read returns 0.
  - 0x410: TXSTAT. RO. Fields:
    - bit0 = full
    - bit1 = empty
    - bit2 = overflow (sticky)
    - bits[8:4] = count
    - other bits 0
  - 0x414: TXCLR. WO. Any write clears overflow. A read returns 0.
- Unmapped reads return 0. Unmapped writes are ignored.
- Writes to RO registers are ignored.
- Reads have no side effects.
- TX FIFO:
  - Circular buffer with read and write pointers plus a count of width $clog2(FIFO_DEPTH)+1.
  - Push: MemWrite && TXDATA && !full, where full is the value before the edge.
  - Push while full: the byte is dropped, the FIFO is unchanged, and overflow is set. This holds even if a pop occurs in the same cycle.
  - Pop: tx_valid && tx_ready.
  - Push and pop in the same cycle when not full and not empty: count is unchanged and both pointers advance.
  - Push into an empty FIFO: the byte appears on tx_data and tx_valid goes high in the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data equals mem[rd_ptr] and is held stable while tx_valid && !tx_ready.
- RAM contents are not cleared by reset and are undefined until written.
- Reset values:
  - led = 0, timer = 0, sw_sync flops = 0
  - FIFO count and pointers = 0; tx_valid = 0, so tx_data is don't-care
  - overflow = 0
- Reset asserted mid-operation discards FIFO contents on the next edge. Any store in the same cycle as reset is ignored, including RAM.

## Timing
- ReadData is purely combinational from Addr and current register/RAM state. It has zero latency, so the core latches a load at the edge that ends the cycle.
- Store visible: the write occurs at the edge where MemWrite=1. A load of the same address in the next cycle returns the new value. A same-cycle read returns the old value.
- sw reaches the SW read value 2 edges after it is stable.
- TIMER reads value N in cycle k and N+1 in cycle k+1.
- A TXSTAT read in the cycle after a push reflects the push.
- tx_valid is registered-state derived (count≠0). It is never combinationally dependent on tx_ready.

## Test plan
- Reset, then store 0xDEADBEEF to 0x010, then load 0x010 next cycle → 0xDEADBEEF. Load 0x013 → same word. Load 0x800 → 0. Store to 0x800 → no RAM/register change.
- Store 0x1A5 to 0x400 → led=0xA5 after the edge; load 0x400 → 0x000000A5. Drive sw=0x3C → load 0x404 returns 0x3C from the 2nd edge on, 0 before.
- Store 0xFFFFFFFE to 0x408, then read on consecutive cycles → 0xFFFFFFFF, then 0x00000000. Reset → timer reads 0.
- tx_ready=0; push 0x41..0x48 (8 bytes) → TXSTAT = full=1, count=8. Push 0x49 → overflow=1, count stays 8. Raise tx_ready → 0x41..0x48 drained in order, one per cycle, then tx_valid=0 and TXSTAT empty=1 with overflow still 1. Write 0x414 → overflow=0.
- tx_ready=1 with count=3; push each cycle for 4 cycles → count stays 3 and bytes exit in FIFO order with no loss.
- Push 3 bytes, assert reset for one cycle alongside a push → count=0, tx_valid=0, led=0, timer=0 after the edge.
